// File: rtl/mem_burst_master_if.sv
// Burst master bundle: command, write stream, read stream
// and the single-port memory bus.
interface mem_burst_master_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output rd_last, busy, done,
    output mem_write, mem_addr, mem_din
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  rd_last, busy, done,
    input  mem_write, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port word memory: one access
// per cycle, write stream in, read stream out via a 2-deep FIFO.
module mem_burst_master #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input logic                clk,
  input logic                reset,
  mem_burst_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              out_q, out_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] fd_q [2];
  logic [DATA_W-1:0] fd_d [2];
  logic [1:0]        fl_q, fl_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;
  logic              issue;
  logic [1:0]        occ;

  assign pop = (cnt_q != 2'd0) && bus.rd_ready;

  // Occupancy after this edge; counting the pop keeps 1 word/cycle.
  assign occ = cnt_q + {1'b0, out_q} - {1'b0, pop};

  assign issue = (state_q == READ)
              && (remain_q != '0)
              && (occ < 2'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    out_d       = issue;
    out_last_d  = out_last_q;
    fd_d        = fd_q;
    fl_d        = fl_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = occ;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          remain_d = bus.cmd_len;
          if (bus.cmd_len == '0)
            state_d = FINISH;
          else if (bus.cmd_write)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid && remain_q != '0) begin
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_din_d   = bus.wr_data;
          addr_d      = addr_q + 1'b1;
          remain_d    = remain_q - 1'b1;
          if (remain_q == LEN_W'(1))
            state_d = FINISH;
        end
      end
      READ: begin
        if (issue) begin
          mem_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          out_last_d = (remain_q == LEN_W'(1));
        end
        if (pop && fl_q[rp_q])
          state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (out_q) begin
      fd_d[wp_q] = bus.mem_dout;
      fl_d[wp_q] = out_last_q;
      wp_d       = ~wp_q;
    end
    if (pop)
      rp_d = ~rp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      out_q       <= 1'b0;
      out_last_q  <= 1'b0;
      fd_q[0]     <= '0;
      fd_q[1]     <= '0;
      fl_q        <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      fd_q        <= fd_d;
      fl_q        <= fl_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.rd_valid  = (cnt_q != 2'd0);
  assign bus.rd_data   = bus.rd_valid ? fd_q[rp_q] : '0;
  assign bus.rd_last   = bus.rd_valid && fl_q[rp_q];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Random and directed bursts against a word-memory model and
// a scoreboard of expected bus writes and read beats.
module tb_mem_burst_master;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk;
  logic reset;

  mem_burst_master_if #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) bus ();

  mem_burst_master #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  logic [AW-1:0] exp_wa [$];
  logic [DW-1:0] exp_wd [$];
  logic [DW-1:0] exp_rd [$];
  bit            exp_rl [$];
  bit            gap_pat [$];

  logic          wr_fire_prev;
  logic          rd_hold;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  logic [AW-1:0] mon_a;
  logic [DW-1:0] mon_d;
  bit            mon_l;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] ra;
  int            rlen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(
    input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Word memory: commits writes and drives read data on negedge.
  always @(negedge clk) begin
    if (bus.mem_write)
      mem[bus.mem_addr] = bus.mem_din;
    bus.mem_dout = mem.exists(bus.mem_addr)
                 ? mem[bus.mem_addr] : '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      wr_fire_prev = 1'b0;
      rd_hold      = 1'b0;
    end else begin
      chk("mem_write_timing", bus.mem_write, wr_fire_prev);
      if (bus.mem_write) begin
        chk("wr_expected", exp_wa.size() != 0, 1);
        if (exp_wa.size() != 0) begin
          mon_a = exp_wa.pop_front();
          mon_d = exp_wd.pop_front();
          chk("mem_addr", bus.mem_addr, mon_a);
          chk("mem_din", bus.mem_din, mon_d);
        end
      end
      if (rd_hold) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_data", bus.rd_data, hold_d);
        chk("rd_hold_last", bus.rd_last, hold_l);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          mon_d = exp_rd.pop_front();
          mon_l = exp_rl.pop_front();
          chk("rd_data", bus.rd_data, mon_d);
          chk("rd_last", bus.rd_last, mon_l);
        end
      end
      rd_hold      = bus.rd_valid && !bus.rd_ready;
      hold_d       = bus.rd_data;
      hold_l       = bus.rd_last;
      wr_fire_prev = bus.wr_valid && bus.wr_ready;
    end
  end

  task automatic send_cmd(input bit w,
                          input logic [AW-1:0] a,
                          input int len);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = LW'(len);
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_handshake", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = LW'($urandom);
  endtask

  task automatic wait_done(input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("done_seen", bus.done, 1);
    chk("done_latency", n, exp_lat);
    chk("rd_idle_at_done", bus.rd_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input int len,
                          input int gap_pct);
    logic [DW-1:0] d;
    logic [AW-1:0] wa;
    bit gap;
    int n;
    send_cmd(1'b1, a, len);
    for (int i = 0; i < len; i++) begin
      d  = $urandom;
      wa = a + AW'(i);
      exp_wa.push_back(wa);
      exp_wd.push_back(d);
      ref_mem[wa] = d;
      if (gap_pat.size() != 0)
        gap = gap_pat.pop_front();
      else
        gap = ($urandom_range(0, 99) < gap_pct);
      if (gap) begin
        @(posedge clk);
        #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      n = 0;
      @(negedge clk);
      while (!bus.wr_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("wr_handshake", bus.wr_ready, 1);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      bus.wr_data  = $urandom;
    end
    wait_done(0);
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         input int len,
                         input int mode);
    int beats = 0;
    int cyc   = 0;
    int first = -1;
    int lastc = 0;
    for (int i = 0; i < len; i++) begin
      exp_rd.push_back(ref_rd(a + AW'(i)));
      exp_rl.push_back(i == len - 1);
    end
    send_cmd(1'b0, a, len);
    while (beats < len && cyc < 200) begin
      case (mode)
        0: bus.rd_ready = 1'b1;
        1: bus.rd_ready = (cyc < 3) ? (cyc == 0)
                                    : (cyc % 2 == 1);
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready) begin
        if (first < 0)
          first = cyc;
        lastc = cyc;
        beats++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.rd_ready = 1'b0;
    chk("rd_beat_count", beats, len);
    if (mode == 0 && len > 0)
      chk("rd_throughput", lastc - first, len - 1);
    wait_done(0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    bus.mem_dout  = '0;
    #1;
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    do_write(24'h000004, 3, 0);
    do_read(24'h000004, 3, 0);
    do_write(24'h000010, 4, 0);
    do_read(24'h000010, 4, 1);
    gap_pat = '{1'b0, 1'b1, 1'b0};
    do_write(24'h000020, 3, 0);
    do_read(24'h000020, 3, 2);
    do_write(24'h000040, 0, 0);
    do_read(24'h000040, 0, 0);
    do_write(24'hFFFFFF, 2, 0);
    do_read(24'hFFFFFF, 2, 0);

    d0 = $urandom;
    d1 = $urandom;
    send_cmd(1'b1, 24'h000300, 4);
    exp_wa.push_back(24'h000300);
    exp_wd.push_back(d0);
    ref_mem[24'h000300] = d0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d0;
    @(negedge clk);
    chk("abort_ready0", bus.wr_ready, 1);
    @(posedge clk);
    #1 bus.wr_data = d1;
    @(negedge clk);
    chk("abort_ready1", bus.wr_ready, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_write", bus.mem_write, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_mem_din", bus.mem_din, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_wr_ready", bus.wr_ready, 0);
    bus.wr_data = $urandom;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_idle_wr_ready", bus.wr_ready, 0);
      chk("abort_idle_done", bus.done, 0);
    end
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    chk("abort_beat0", mem.exists(24'h000300)
        ? mem[24'h000300] : '0, d0);
    chk("abort_beat1", mem.exists(24'h000301), 0);
    chk("abort_beat2", mem.exists(24'h000302), 0);
    chk("abort_beat3", mem.exists(24'h000303), 0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0)
        ra = 24'hFFFFFF - AW'($urandom_range(0, 3));
      else
        ra = AW'($urandom_range(0, 48));
      rlen = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1)
        do_write(ra, rlen, 30);
      else
        do_read(ra, rlen, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", exp_wa.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    foreach (ref_mem[a])
      chk("mem_image", mem.exists(a) ? mem[a] : '0,
          ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
